sc_accum: RTL

SC_ACCUM -- requirements
Module: sc_accum

---
 rtl/sc_pkg.sv | 16 +
 rtl/sc_accum_if.sv | 29 ++
 rtl/sc_accum_popcount.sv | 19 +
 rtl/sc_accum.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing dot-product accumulator.
//   state_t   : accumulator FSM states (S_ACC collecting terms, S_OUT holding a result)
//   popcnt_w  : width needed to count every bit of a BITSTREAM-wide vector
package sc_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Wide enough to hold BITSTREAM itself, not just BITSTREAM-1.
  function automatic int popcnt_w(input int bitstream);
    return $clog2(bitstream) + 1;
  endfunction

endpackage

// File: rtl/sc_accum_if.sv
// Handshake bundle around sc_accum.
//   bit_a/bit_b : activation / weight streams       valid/last : input beat qualifiers
//   ready       : block accepts a beat              res_valid  : result held on sum/ovf
//   res_ready   : downstream consumes the result    sum/ovf    : result and saturation flag
// master = producer/consumer side, slave = accumulator side.
interface sc_accum_if #(
  parameter int BITSTREAM = 64,
  parameter int ACC_W     = 16
) ();
  logic [BITSTREAM-1:0] bit_a;
  logic [BITSTREAM-1:0] bit_b;
  logic                 valid;
  logic                 last;
  logic                 ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_W-1:0]     sum;
  logic                 ovf;

  modport master (
    output bit_a, bit_b, valid, last, res_ready,
    input  ready, res_valid, sum, ovf
  );

  modport slave (
    input  bit_a, bit_b, valid, last, res_ready,
    output ready, res_valid, sum, ovf
  );
endinterface

// File: rtl/sc_accum_popcount.sv
// POPCOUNT: combinational count of set bits in a BITSTREAM-wide vector.
//   vec_i   : input vector
//   count_o : number of ones, 0..BITSTREAM
module POPCOUNT
  import sc_pkg::*;
#(
  parameter int BITSTREAM = 64
) (
  input  logic [BITSTREAM-1:0]           vec_i,
  output logic [popcnt_w(BITSTREAM)-1:0] count_o
);
  localparam int CNT_W = popcnt_w(BITSTREAM);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < BITSTREAM; i++)
      count_o = count_o + CNT_W'(vec_i[i]);
  end
endmodule

// File: rtl/sc_accum.sv
// sc_accum: accumulates unipolar SC products popcount(A & B) over a dot
// product and presents the saturated sum with a valid/ready handshake.
//   iClk, iRst               : clock (rising edge), async active-high reset
//   iBitstreamA/B            : activation / weight streams
//   iValid, iLast, oReady    : input beat handshake, iLast marks final term
//   oValid, iReady           : result handshake
//   oSum, oOverflow          : saturated result and "saturation occurred" flag
module sc_accum
  import sc_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int ACC_W     = 16
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [BITSTREAM-1:0] iBitstreamA,
  input  logic [BITSTREAM-1:0] iBitstreamB,
  input  logic                 iValid,
  input  logic                 iLast,
  output logic                 oReady,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [ACC_W-1:0]     oSum,
  output logic                 oOverflow
);
  localparam int CNT_W = popcnt_w(BITSTREAM);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] term;
  logic [ACC_W-1:0] term_ext;
  logic [ACC_W-1:0] base_acc;
  logic             base_ovf;
  logic [ACC_W:0]   wide;
  logic [ACC_W-1:0] add_val;
  logic             add_ovf;

  POPCOUNT #(.BITSTREAM(BITSTREAM)) u_popcount (
    .vec_i   (iBitstreamA & iBitstreamB),
    .count_o (term)
  );

  assign term_ext = ACC_W'(term);

  // A beat accepted while a result is being consumed starts a fresh sum,
  // so the adder base is zero whenever we are in S_OUT.
  always_comb begin
    base_acc = (state_q == S_ACC) ? acc_q     : '0;
    base_ovf = (state_q == S_ACC) ? acc_ovf_q : 1'b0;
    wide     = {1'b0, base_acc} + {1'b0, term_ext};
    add_val  = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
    add_ovf  = base_ovf | wide[ACC_W];
  end

  assign oReady    = (state_q == S_ACC) || iReady;
  assign oValid    = (state_q == S_OUT);
  assign oSum      = sum_q;
  assign oOverflow = ovf_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_ACC: begin
        if (iValid) begin
          if (iLast) begin
            sum_d     = add_val;
            ovf_d     = add_ovf;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            state_d   = S_OUT;
          end else begin
            acc_d     = add_val;
            acc_ovf_d = add_ovf;
          end
        end
      end
      S_OUT: begin
        if (iReady) begin
          // Result consumed; a same-cycle beat restarts from zero.
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          state_d   = S_ACC;
          if (iValid) begin
            if (iLast) begin
              sum_d   = add_val;
              ovf_d   = add_ovf;
              state_d = S_OUT;
            end else begin
              acc_d     = add_val;
              acc_ovf_d = add_ovf;
            end
          end
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_ACC;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule
